// File: rtl/mat_result_streamer.sv
// Captures a parallel result matrix on the rising edge of mult_done and
// replays it as a row-major valid/ready stream with row/column tags.
module mat_result_streamer #(
    parameter int  N_ROWS     = 3,
    parameter int  N_COLUMNS  = 2,
    parameter int  DATA_WIDTH = 32,
    localparam int ROW_W      = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
    localparam int COL_W      = (N_COLUMNS > 1) ? $clog2(N_COLUMNS) : 1,
    localparam int N_ELEM     = N_ROWS * N_COLUMNS,
    localparam int IDX_W      = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mult_done,
    input  logic [N_ELEM*DATA_WIDTH-1:0] mat_in,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [ROW_W-1:0]             out_row,
    output logic [COL_W-1:0]             out_col,
    output logic                         out_last,
    output logic                         busy,
    output logic                         overrun,
    output logic [15:0]                  frame_count
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_e;

    state_e                       state_q;
    logic                         mult_done_q;
    logic [N_ELEM*DATA_WIDTH-1:0] buf_q;
    logic [IDX_W-1:0]             idx_q;
    logic                         out_valid_q;
    logic [DATA_WIDTH-1:0]        out_data_q;
    logic [ROW_W-1:0]             out_row_q;
    logic [COL_W-1:0]             out_col_q;
    logic                         out_last_q;
    logic                         busy_q;
    logic                         overrun_q;
    logic [15:0]                  frame_count_q;

    logic                         rise_s;
    logic                         xfer_s;
    logic                         last_xfer_s;
    logic                         capture_s;
    logic [IDX_W-1:0]             next_idx_d;

    assign rise_s      = mult_done & ~mult_done_q;
    assign xfer_s      = out_valid_q & out_ready;
    assign last_xfer_s = (state_q == S_STREAM) & xfer_s & (idx_q == IDX_W'(N_ELEM - 1));
    // A rise is only accepted when idle or when it lines up with the final beat.
    assign capture_s   = rise_s & ((state_q == S_IDLE) | last_xfer_s);
    assign next_idx_d  = idx_q + IDX_W'(1);

    // Capture/stream state machine with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            mult_done_q   <= 1'b0;
            buf_q         <= '0;
            idx_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_row_q     <= '0;
            out_col_q     <= '0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            mult_done_q <= mult_done;

            if (last_xfer_s) begin
                frame_count_q <= frame_count_q + 16'd1;
            end else begin
                frame_count_q <= frame_count_q;
            end

            if (rise_s && (state_q == S_STREAM) && !last_xfer_s) begin
                overrun_q <= 1'b1;
            end else begin
                overrun_q <= overrun_q;
            end

            if (capture_s) begin
                state_q     <= S_STREAM;
                buf_q       <= mat_in;
                idx_q       <= '0;
                out_valid_q <= 1'b1;
                busy_q      <= 1'b1;
                out_data_q  <= mat_in[DATA_WIDTH-1:0];
                out_row_q   <= '0;
                out_col_q   <= '0;
                out_last_q  <= (N_ELEM == 1);
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_IDLE;
                    end
                    S_STREAM: begin
                        if (last_xfer_s) begin
                            state_q     <= S_IDLE;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else if (xfer_s) begin
                            idx_q      <= next_idx_d;
                            out_data_q <= buf_q[int'(next_idx_d)*DATA_WIDTH +: DATA_WIDTH];
                            out_last_q <= (next_idx_d == IDX_W'(N_ELEM - 1));
                            if (out_col_q == COL_W'(N_COLUMNS - 1)) begin
                                out_col_q <= '0;
                                out_row_q <= out_row_q + ROW_W'(1);
                            end else begin
                                out_col_q <= out_col_q + COL_W'(1);
                            end
                        end else begin
                            state_q <= S_STREAM;
                        end
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_row     = out_row_q;
    assign out_col     = out_col_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_mat_result_streamer.sv
// Directed bench for mat_result_streamer (3x2, 32-bit): inputs driven and
// outputs checked on the falling clock edge.
module tb_mat_result_streamer;

    logic         clk = 1'b0;
    logic         reset;
    logic         mult_done;
    logic [191:0] mat_in;
    logic         out_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_row;
    logic [0:0]   out_col;
    logic         out_last;
    logic         busy;
    logic         overrun;
    logic [15:0]  frame_count;

    int n_cmp = 0;
    int n_err = 0;

    int mat_a[6] = '{1, 4, 9, 16, 25, 36};
    int mat_7[6] = '{7, 7, 7, 7, 7, 7};
    int mat_b[6] = '{-1, -2, -3, -4, -5, -6};
    int mat_c[6] = '{100, -200, 300, -400, 500, -600};

    always #5 clk = ~clk;

    mat_result_streamer #(
        .N_ROWS     (3),
        .N_COLUMNS  (2),
        .DATA_WIDTH (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mult_done   (mult_done),
        .mat_in      (mat_in),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_last    (out_last),
        .busy        (busy),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_mat(input int m[6]);
        for (int i = 0; i < 6; i++) mat_in[i*32 +: 32] = m[i];
    endtask

    // Single-cycle mult_done pulse; returns on the negedge where beat 0 is visible.
    task automatic pulse_done();
        mult_done = 1'b1;
        @(negedge clk);
        mult_done = 1'b0;
        mat_in    = {6{32'hDEAD_BEEF}};
    endtask

    // Walks one frame: mode 0 keeps ready high, mode 1 uses ready 1,0,0,...
    // At beat trig_k a new mult_done rise with trig_m on mat_in is injected once.
    task automatic stream(input string tag, input int e[6], input int mode,
                          input int trig_k, input int trig_m[6]);
        int  k     = 0;
        int  cyc   = 0;
        bit  fired = 1'b0;
        while (k < 6 && cyc < 60) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (trig_k >= 0) begin
                if (k == trig_k && !fired) begin
                    set_mat(trig_m);
                    mult_done = 1'b1;
                    fired     = 1'b1;
                end else begin
                    mult_done = 1'b0;
                end
            end
            chk({tag, ".valid"}, out_valid, 1);
            chk({tag, ".data"},  $signed(out_data), e[k]);
            chk({tag, ".row"},   out_row, k / 2);
            chk({tag, ".col"},   out_col, k % 2);
            chk({tag, ".last"},  out_last, (k == 5));
            if (out_ready) k++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".beats"}, k, 6);
    endtask

    initial begin
        reset     = 1'b0;
        mult_done = 1'b0;
        out_ready = 1'b0;
        mat_in    = '0;
        repeat (3) @(negedge clk);
        chk("rst.valid", out_valid, 0);
        chk("rst.data",  out_data, 0);
        chk("rst.row",   out_row, 0);
        chk("rst.col",   out_col, 0);
        chk("rst.last",  out_last, 0);
        chk("rst.busy",  busy, 0);
        chk("rst.ovr",   overrun, 0);
        chk("rst.fc",    frame_count, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle.valid", out_valid, 0);

        // Basic frame, ready always high.
        set_mat(mat_a);
        pulse_done();
        stream("basic", mat_a, 0, -1, mat_7);
        chk("basic.valid_after", out_valid, 0);
        chk("basic.busy_after",  busy, 0);
        chk("basic.last_after",  out_last, 0);
        chk("basic.fc",          frame_count, 1);
        chk("basic.data_hold",   out_data, 36);
        chk("basic.row_hold",    out_row, 2);
        chk("basic.col_hold",    out_col, 1);

        // Backpressure.
        set_mat(mat_a);
        pulse_done();
        stream("bp", mat_a, 1, -1, mat_7);
        chk("bp.valid_after", out_valid, 0);
        chk("bp.fc",          frame_count, 2);

        // Overrun: new rise during the third beat is dropped.
        set_mat(mat_a);
        pulse_done();
        stream("ovr", mat_a, 0, 2, mat_7);
        mult_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovr.flag",  overrun, 1);
        chk("ovr.valid", out_valid, 0);
        chk("ovr.busy",  busy, 0);
        chk("ovr.fc",    frame_count, 3);

        // Reset in the middle of a frame.
        set_mat(mat_a);
        pulse_done();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid.pre_data", out_data, 9);
        reset = 1'b0;
        #1;
        chk("mid.valid", out_valid, 0);
        chk("mid.data",  out_data, 0);
        chk("mid.row",   out_row, 0);
        chk("mid.col",   out_col, 0);
        chk("mid.busy",  busy, 0);
        chk("mid.ovr",   overrun, 0);
        chk("mid.fc",    frame_count, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid.valid_released", out_valid, 0);
        set_mat(mat_a);
        pulse_done();
        stream("mid.restart", mat_a, 0, -1, mat_7);
        chk("mid.fc_after", frame_count, 1);

        // Back-to-back: frame B captured on the last transfer of frame A.
        set_mat(mat_a);
        pulse_done();
        stream("b2b.a", mat_a, 0, 5, mat_b);
        mult_done = 1'b0;
        stream("b2b.b", mat_b, 0, -1, mat_7);
        chk("b2b.fc",    frame_count, 3);
        chk("b2b.ovr",   overrun, 0);
        chk("b2b.valid", out_valid, 0);

        // Level mult_done held for 10 cycles yields a single frame.
        set_mat(mat_c);
        mult_done = 1'b1;
        @(negedge clk);
        stream("lvl", mat_c, 0, -1, mat_7);
        repeat (3) @(negedge clk);
        chk("lvl.valid", out_valid, 0);
        chk("lvl.busy",  busy, 0);
        chk("lvl.fc",    frame_count, 4);
        mult_done = 1'b0;
        @(negedge clk);

        // Frame counter wrap from 0xFFFF.
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_q;
        @(negedge clk);
        chk("wrap.preset", frame_count, 16'hFFFF);
        set_mat(mat_a);
        pulse_done();
        stream("wrap", mat_a, 0, -1, mat_7);
        chk("wrap.fc", frame_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mat_result_streamer.md
Name: mat_result_streamer

Overview:
Consumer-side companion to mat_mult. It waits for mult_done, captures the full N_ROWS x N_COLUMNS result matrix (mat_out) into an internal buffer, then streams the elements out one per handshake over a valid/ready interface in row-major order with row/column tags and a last flag. It decouples the parallel matrix result from serial downstream logic (UART/FIFO/checker).

Parameters:
N_ROWS, 3, matrix rows
N_COLUMNS, 2, matrix columns
DATA_WIDTH, 32, element width in bits (signed, matches int)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
mult_done  input  1  level from mat_mult; rising edge means mat_in is valid
mat_in  input  N_ROWS*N_COLUMNS*DATA_WIDTH  flattened result; element [i][j] at bit offset (i*N_COLUMNS+j)*DATA_WIDTH
out_ready  input  1  downstream accepts element
out_valid  output  1  out_data/out_row/out_col/out_last valid
out_data  output  DATA_WIDTH  current element
out_row  output  $clog2(N_ROWS) (min 1)  row index of out_data
out_col  output  $clog2(N_COLUMNS) (min 1)  column index of out_data
out_last  output  1  high with final element (N_ROWS-1, N_COLUMNS-1)
busy  output  1  high in STREAM
overrun  output  1  sticky: new result arrived while streaming and was dropped
frame_count  output  16  completed matrices, wraps 0xFFFF->0

Behaviour:
- Reset (reset=0, async): state IDLE, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0, overrun=0, frame_count=0, mult_done_q=0, buffer cleared.
- Edge detect: rise = mult_done & ~mult_done_q; mult_done_q registered every cycle. mult_done already high on reset release counts as a rise.
- States: IDLE, STREAM.
- IDLE: on rise, capture mat_in into buffer, idx=0 (row=0,col=0), go STREAM. Latency: rise sampled at edge k -> out_valid=1 with element [0][0] after edge k.
- STREAM: out_valid=1, busy=1, out_data=buffer[idx]; out_last=1 iff idx=N_ROWS*N_COLUMNS-1.
- Handshake: transfer when out_valid & out_ready at a rising edge. While out_valid & ~out_ready, all out_* held stable. out_valid never drops in STREAM without a transfer.
- On transfer, non-last: col++; when col=N_COLUMNS-1, col=0 and row++.
- On transfer of last: frame_count++ (mod 2^16); if rise in same cycle -> recapture mat_in, idx=0, stay STREAM (back-to-back, no bubble); else -> IDLE, out_valid=0 next cycle.
- Rise in STREAM other than the last-transfer cycle: mat_in ignored, buffer unchanged, overrun set to 1; cleared only by reset.
- Buffer changes only at capture; mat_in may change freely after capture.
- In IDLE, out_data/out_row/out_col retain last values; out_last=0.
- Reset mid-stream: immediate abort to reset values; frame not counted; no partial resume.
- N_ROWS=1 or N_COLUMNS=1 supported; 1x1: single element with out_last=1.

Test Plan:
- Basic: mat_in={{1,4},{9,16},{25,36}}, pulse mult_done, out_ready=1 -> 6 beats on consecutive cycles: 1,4,9,16,25,36; (row,col) (0,0)..(2,1); out_last only on 36; frame_count=1; busy low after.
- Backpressure: same matrix, out_ready toggling 1,0,0,1,... -> data/tags held while stalled, no dropped or duplicated beats, order unchanged.
- Overrun: during beat 3 raise new mult_done with mat_in={{7,7},{7,7},{7,7}} -> stream still 1,4,9,16,25,36, overrun=1, stays 1 until reset.
- Back-to-back: rise coincident with last transfer of frame A, frame B={{-1,-2},{-3,-4},{-5,-6}} -> B's -1 valid the very next cycle, frame_count=2 after B, overrun=0.
- Reset mid-stream: assert reset after beat 2 -> all outputs zero immediately; after release with mult_done low, out_valid stays 0; next rise streams full frame from [0][0].
- Level mult_done held high for 10 cycles -> exactly one frame captured; frame_count wrap preset test 0xFFFF -> 0.
